hit_resolver: RTL
=================

Name: hit_resolver

Overview:
Per-frame laser/alien collision stage that sits between the laser/formation pixel generators and the laser, formation and score logic. It samples pixel overlap during active video and latches the first hit coordinate. At the vsync frame boundary it resolves that coordinate to an alien row/column, then issues a kill pulse and a frame-long hit_alien level, which the cannon laser consumes. It also maintains a 4-digit BCD score.

Parameters:
NUM_ROWS, 2, formation rows
NUM_COLUMNS, 4, formation columns
ALIEN_SPACING_X, 64, column pitch in pixels; power of two required
ALIEN_SPACING_Y, 32, row pitch in pixels; power of two required
POINTS_PER_HIT, 1, BCD points added per kill (1..9)
VSYNC_POL, 0, active level of vsync (0 = active-low)
FLASH_FRAMES, 8, hit_flash duration in frames (only with HIT_FLASH_EN)

Ports:
clk  in  1  pixel clock
rst_n  in  1  reset, synchronous, active-low
hpos  in  10  current scan x
vpos  in  10  current scan y
display_on  in  1  active video
vsync  in  1  vertical sync from hvsync_generator
laser_gfx  in  1  laser pixel
alien_pixel  in  1  alien pixel
laser_active  in  1  laser in flight
formation_x  in  10  formation origin x
formation_y  in  10  formation origin y
alive_matrix  in  NUM_ROWS*NUM_COLUMNS  alive mask, bit = row*NUM_COLUMNS+col
hit_alien  out  1  level; a hit was resolved at the last frame boundary
kill_valid  out  1  one-cycle kill pulse
kill_row  out  $clog2(NUM_ROWS) (min 1)  killed row, valid with kill_valid
kill_col  out  $clog2(NUM_COLUMNS) (min 1)  killed column, valid with kill_valid
score_bcd  out  16  four BCD digits, [15:12] = thousands
hit_flash  out  1  flash request (see Optional Feature)

Behaviour:
- Reset (rst_n low at clk edge): all outputs 0, score_bcd 16'h0000, state SCAN, vsync_q = inactive level.
- Overlap = display_on & laser_gfx & alien_pixel & laser_active.
- Frame edge: a cycle in which vsync equals VSYNC_POL and vsync_q does not. vsync_q is vsync registered.
- FSM:
  - SCAN: first overlap latches cap_x = hpos and cap_y = vpos, then moves to CAPTURED. A frame edge in SCAN moves to REPORT with no hit.
  - CAPTURED: further overlaps are ignored (first hit wins). A frame edge moves to REPORT with hit pending.
  - REPORT: exactly one cycle, then returns to SCAN.
- Resolution in REPORT:
  - Hit is discarded if cap_x < formation_x or cap_y < formation_y. Both comparisons are made before subtracting, using unsigned 10-bit arithmetic.
  - col = (cap_x - formation_x) >> log2(ALIEN_SPACING_X); row = (cap_y - formation_y) >> log2(ALIEN_SPACING_Y).
  - Hit is discarded if col >= NUM_COLUMNS, row >= NUM_ROWS, or alive_matrix bit is 0.
- Outputs at the cycle after REPORT (latency 2 clk from the frame edge):
  - Valid hit: kill_valid = 1 for one cycle with kill_row/kill_col; hit_alien = 1; score_bcd += POINTS_PER_HIT with BCD carry.
  - No valid hit: hit_alien = 0, kill_valid = 0.
- hit_alien holds its value until the next REPORT, i.e. one full frame, so vsync-clocked consumers see it.
- Score saturates at 16'h9999; no wrap.
- An overlap in the same cycle as a frame edge: the edge is processed first, and the overlap is ignored.
- rst_n low mid-frame or mid-REPORT aborts the operation: no kill_valid is emitted and the score clears.

Optional Feature:
HIT_FLASH_EN
- Defined: a frame counter loads FLASH_FRAMES on each valid kill and decrements at each frame edge while nonzero. hit_flash = (counter != 0). A new kill reloads the counter. Reset clears it.
- Undefined: hit_flash is tied to 0 and no counter exists.

Test Plan:
- Reset, then 2 frames with no overlap -> hit_alien 0, kill_valid never 1, score_bcd 16'h0000.
- formation 100/50, all alive, overlap at hpos 230 vpos 60 -> kill_valid pulse 2 clk after the next frame edge, row 0 col 2, score 16'h0001, hit_alien high for exactly one frame.
- Overlaps at (230,60), then (300,90) in the same frame -> single kill at row 0 col 2; the second overlap is ignored.
- Overlap at (90,60) (left of origin), or at (400,60) (col 4 >= NUM_COLUMNS), or on a dead cell with alive_matrix bit 2 = 0 -> no kill, hit_alien 0.
- Preload 9998 via 9998 kills (or force), then two more kills -> 16'h9999, then stays 16'h9999; check BCD carry 0009 -> 0010.
- rst_n low during CAPTURED -> no kill_valid after release, score 0. With HIT_FLASH_EN defined, a kill -> hit_flash high for 8 frames, then low.

Source files
------------

// File: rtl/hit_resolver_if.sv
// Pixel-side inputs and kill/score outputs of hit_resolver.
// Master drives the scan inputs; slave is the resolver itself.
interface hit_resolver_if #(
    parameter int NUM_ROWS    = 2,
    parameter int NUM_COLUMNS = 4
);
    localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int COL_W = (NUM_COLUMNS > 1) ? $clog2(NUM_COLUMNS) : 1;

    logic [9:0]                         hpos;
    logic [9:0]                         vpos;
    logic                               display_on;
    logic                               vsync;
    logic                               laser_gfx;
    logic                               alien_pixel;
    logic                               laser_active;
    logic [9:0]                         formation_x;
    logic [9:0]                         formation_y;
    logic [NUM_ROWS*NUM_COLUMNS-1:0]    alive_matrix;
    logic                               hit_alien;
    logic                               kill_valid;
    logic [ROW_W-1:0]                   kill_row;
    logic [COL_W-1:0]                   kill_col;
    logic [15:0]                        score_bcd;
    logic                               hit_flash;

    modport master (
        output hpos, vpos, display_on, vsync, laser_gfx, alien_pixel, laser_active,
               formation_x, formation_y, alive_matrix,
        input  hit_alien, kill_valid, kill_row, kill_col, score_bcd, hit_flash
    );

    modport slave (
        input  hpos, vpos, display_on, vsync, laser_gfx, alien_pixel, laser_active,
               formation_x, formation_y, alive_matrix,
        output hit_alien, kill_valid, kill_row, kill_col, score_bcd, hit_flash
    );
endinterface

// File: rtl/hit_resolver.sv
// First-hit laser/alien capture, per-frame resolve to row/col, saturating BCD score; HIT_FLASH_EN adds a hit_flash frame counter.
// Kill/score appear 2 clk after the vsync frame edge; no backpressure, inputs are sampled every pixel clock.
module hit_resolver #(
    parameter int   NUM_ROWS        = 2,
    parameter int   NUM_COLUMNS     = 4,
    parameter int   ALIEN_SPACING_X = 64,
    parameter int   ALIEN_SPACING_Y = 32,
    parameter int   POINTS_PER_HIT  = 1,
    parameter logic VSYNC_POL       = 1'b0,
    parameter int   FLASH_FRAMES    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    hit_resolver_if.slave bus
);
    localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int COL_W = (NUM_COLUMNS > 1) ? $clog2(NUM_COLUMNS) : 1;
    localparam int SHX   = $clog2(ALIEN_SPACING_X);
    localparam int SHY   = $clog2(ALIEN_SPACING_Y);
    localparam logic [3:0] PTS = 4'(POINTS_PER_HIT);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        CAPTURED = 2'd1,
        REPORT   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             vsync_q;
    logic [9:0]       cap_x_q, cap_x_d;
    logic [9:0]       cap_y_q, cap_y_d;
    logic             pending_q, pending_d;
    logic             hit_alien_q, hit_alien_d;
    logic             kill_valid_q, kill_valid_d;
    logic [ROW_W-1:0] kill_row_q, kill_row_d;
    logic [COL_W-1:0] kill_col_q, kill_col_d;
    logic [15:0]      score_q, score_d;

    logic       frame_edge;
    logic       overlap;
    logic [9:0] dx, dy, col_full, row_full;
    logic       alive_bit;
    logic       hit_ok;

    // Per-digit add with carry; any carry out of the thousands digit pins the score at 9999.
    function automatic logic [15:0] bcd_add_sat(input logic [15:0] v, input logic [3:0] pts);
        logic [15:0] r;
        logic [4:0]  s;
        logic [4:0]  c;
        r = '0;
        c = {1'b0, pts};
        for (int i = 0; i < 4; i++) begin
            s = {1'b0, v[i*4 +: 4]} + c;
            if (s > 5'd9) begin
                r[i*4 +: 4] = 4'(s - 5'd10);
                c = 5'd1;
            end else begin
                r[i*4 +: 4] = s[3:0];
                c = 5'd0;
            end
        end
        return (c != 5'd0) ? 16'h9999 : r;
    endfunction

    assign frame_edge = (bus.vsync == VSYNC_POL) && (vsync_q != VSYNC_POL);
    assign overlap    = bus.display_on & bus.laser_gfx & bus.alien_pixel & bus.laser_active;

    always_comb begin
        dx        = cap_x_q - bus.formation_x;
        dy        = cap_y_q - bus.formation_y;
        col_full  = dx >> SHX;
        row_full  = dy >> SHY;
        alive_bit = 1'b0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            for (int c = 0; c < NUM_COLUMNS; c++) begin
                if (row_full == 10'(r) && col_full == 10'(c)) begin
                    alive_bit = bus.alive_matrix[r*NUM_COLUMNS + c];
                end
            end
        end
        // Origin checks use the raw capture so an underflowed difference never resolves.
        hit_ok = pending_q
               && (cap_x_q >= bus.formation_x)
               && (cap_y_q >= bus.formation_y)
               && (col_full < 10'(NUM_COLUMNS))
               && (row_full < 10'(NUM_ROWS))
               && alive_bit;
    end

    always_comb begin
        state_d      = state_q;
        cap_x_d      = cap_x_q;
        cap_y_d      = cap_y_q;
        pending_d    = pending_q;
        hit_alien_d  = hit_alien_q;
        kill_valid_d = 1'b0;
        kill_row_d   = kill_row_q;
        kill_col_d   = kill_col_q;
        score_d      = score_q;
        case (state_q)
            SCAN: begin
                if (frame_edge) begin
                    state_d   = REPORT;
                    pending_d = 1'b0;
                end else if (overlap) begin
                    cap_x_d = bus.hpos;
                    cap_y_d = bus.vpos;
                    state_d = CAPTURED;
                end
            end
            CAPTURED: begin
                if (frame_edge) begin
                    state_d   = REPORT;
                    pending_d = 1'b1;
                end
            end
            REPORT: begin
                state_d     = SCAN;
                pending_d   = 1'b0;
                hit_alien_d = hit_ok;
                if (hit_ok) begin
                    kill_valid_d = 1'b1;
                    kill_row_d   = ROW_W'(row_full);
                    kill_col_d   = COL_W'(col_full);
                    score_d      = bcd_add_sat(score_q, PTS);
                end
            end
            default: state_d = SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= SCAN;
            vsync_q      <= ~VSYNC_POL;
            cap_x_q      <= '0;
            cap_y_q      <= '0;
            pending_q    <= 1'b0;
            hit_alien_q  <= 1'b0;
            kill_valid_q <= 1'b0;
            kill_row_q   <= '0;
            kill_col_q   <= '0;
            score_q      <= 16'h0000;
        end else begin
            state_q      <= state_d;
            vsync_q      <= bus.vsync;
            cap_x_q      <= cap_x_d;
            cap_y_q      <= cap_y_d;
            pending_q    <= pending_d;
            hit_alien_q  <= hit_alien_d;
            kill_valid_q <= kill_valid_d;
            kill_row_q   <= kill_row_d;
            kill_col_q   <= kill_col_d;
            score_q      <= score_d;
        end
    end

    assign bus.hit_alien  = hit_alien_q;
    assign bus.kill_valid = kill_valid_q;
    assign bus.kill_row   = kill_row_q;
    assign bus.kill_col   = kill_col_q;
    assign bus.score_bcd  = score_q;

`ifdef HIT_FLASH_EN
    localparam int FL_W = $clog2(FLASH_FRAMES + 1);
    logic [FL_W-1:0] flash_q, flash_d;

    always_comb begin
        flash_d = flash_q;
        if (state_q == REPORT && hit_ok) begin
            flash_d = FL_W'(FLASH_FRAMES);
        end else if (frame_edge && flash_q != '0) begin
            flash_d = flash_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flash_q <= '0;
        end else begin
            flash_q <= flash_d;
        end
    end

    assign bus.hit_flash = (flash_q != '0);
`else
    localparam int UNUSED_FLASH_FRAMES = FLASH_FRAMES;
    assign bus.hit_flash = 1'b0;
`endif
endmodule
